// File: rtl/rotate_scan_ctrl.sv
// rtl/rotate_scan_ctrl.sv - frame-scan sequencer with credit pacing and pipeline-aligned strobes
// Walks the rotated raster once per start and tags pixels so strobes land with BRAM data.
module rotate_scan_ctrl #(
    parameter int OUT_W    = 480,
    parameter int OUT_H    = 640,
    parameter int CREDITS  = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        abort_in,
    input  logic        credit_return_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        valid_out,
    output logic        pixel_valid_out,
    output logic        sof_out,
    output logic        eol_out,
    output logic        eof_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        aborted_out,
    output logic        credit_err_out
);

    localparam int              CW       = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);
    localparam logic [10:0]     H_LAST   = 11'(OUT_W - 1);
    localparam logic [9:0]      V_LAST   = 10'(OUT_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [10:0]    h_q;
    logic [10:0]    h_d;
    logic [9:0]     v_q;
    logic [9:0]     v_d;
    logic [10:0]    hcount_q;
    logic [9:0]     vcount_q;
    logic [CW-1:0]  credit_q;
    logic [CW-1:0]  credit_d;
    logic           credit_err_q;
    logic           credit_err_d;
    logic           abort_flag_q;
    logic           busy_q;
    logic           done_q;
    logic           aborted_q;
    logic           issue;
    logic           last_pix;
    logic           drained;

    // Tag bits: [3] valid, [2] sof, [1] eol, [0] eof.
    logic [3:0]     issue_tag_q;
    logic [3:0]     pipe_q [PIPE_LAT];

    always_comb begin
        issue    = (state_q == S_SCAN) && (credit_q != '0) && !abort_in;
        last_pix = (h_q == H_LAST) && (v_q == V_LAST);
        h_d      = h_q;
        v_d      = v_q;
        if ((state_q == S_IDLE) && start_in) begin
            h_d = '0;
            v_d = '0;
        end else if (issue) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (issue && !credit_return_in) begin
            credit_d = credit_q - CW'(1);
        end else if (!issue && credit_return_in) begin
            if (credit_q == CRED_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    // The final pipe stage is leaving this cycle, so it no longer holds the frame open.
    always_comb begin
        drained = !issue_tag_q[3];
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            if (pipe_q[i][3]) begin
                drained = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            credit_q     <= CRED_MAX;
            credit_err_q <= 1'b0;
            abort_flag_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            issue_tag_q  <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            hcount_q     <= issue ? h_q : h_d;
            vcount_q     <= issue ? v_q : v_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            issue_tag_q  <= {issue,
                             issue && (h_q == '0) && (v_q == '0),
                             issue && (h_q == H_LAST),
                             issue && last_pix};
            pipe_q[0]    <= issue_tag_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    abort_flag_q <= 1'b0;
                    busy_q       <= start_in;
                    if (start_in) begin
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    busy_q <= 1'b1;
                    if (abort_in) begin
                        state_q      <= S_DRAIN;
                        abort_flag_q <= 1'b1;
                    end else if (issue && last_pix) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    busy_q <= 1'b1;
                    if (drained) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        aborted_q <= abort_flag_q;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    abort_flag_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign valid_out       = issue_tag_q[3];
    assign pixel_valid_out = pipe_q[PIPE_LAT-1][3];
    assign sof_out         = pipe_q[PIPE_LAT-1][2];
    assign eol_out         = pipe_q[PIPE_LAT-1][1];
    assign eof_out         = pipe_q[PIPE_LAT-1][0];
    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign aborted_out     = aborted_q;
    assign credit_err_out  = credit_err_q;

endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// tb/tb_rotate_scan_ctrl.sv - directed and randomized checks of rotate_scan_ctrl
// Reference model tracks a linear pixel index, a credit count and a cycle-keyed map of due pixels.
module tb_rotate_scan_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int CRED = 16;
    localparam int LAT  = 3;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ret = 1'b0;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        valid, pvalid, sof, eol, eof, busy, done, aborted, cerr;

    always #5 clk = ~clk;

    rotate_scan_ctrl #(
        .OUT_W(W), .OUT_H(H), .CREDITS(CRED), .PIPE_LAT(LAT)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start), .abort_in(abort),
        .credit_return_in(ret), .hcount_out(hcount), .vcount_out(vcount),
        .valid_out(valid), .pixel_valid_out(pvalid), .sof_out(sof), .eol_out(eol),
        .eof_out(eof), .busy_out(busy), .done_out(done), .aborted_out(aborted),
        .credit_err_out(cerr)
    );

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    int m_mode;
    int m_p, m_cred, m_last_issue;
    bit m_ab, m_err;
    bit e_valid, e_busy, e_done, e_abo;
    int e_h, e_v;
    bit [3:0] pix_due [int];

    int s_nvalid, s_first_valid, s_first_h, s_first_v, s_eof, s_eof_at, s_done_at, s_done_abo;
    int base, rc;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_p = 0; m_cred = CRED; m_last_issue = -1000;
        m_ab = 0; m_err = 0;
        e_valid = 0; e_busy = 0; e_done = 0; e_abo = 0; e_h = 0; e_v = 0;
        pix_due.delete();
    endtask

    task automatic model_edge(input bit s, input bit a, input bit r);
        bit issue;
        int p_next;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        issue = (m_mode == 1) && (m_cred > 0) && !a;
        p_next = m_p;
        e_done = 0;
        e_abo = 0;
        if (m_mode == 0) begin
            if (s) begin m_mode = 1; p_next = 0; m_ab = 0; end
        end else if (m_mode == 1) begin
            if (a) begin
                m_mode = 2; m_ab = 1;
            end else if (issue) begin
                pix_due[cyc + LAT] = {1'b1, m_p == 0, (m_p % W) == W - 1, m_p == NPIX - 1};
                m_last_issue = cyc;
                p_next = (m_p == NPIX - 1) ? 0 : m_p + 1;
                if (m_p == NPIX - 1) m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (cyc >= m_last_issue + LAT + 1) begin
                m_mode = 3; e_done = 1; e_abo = m_ab;
            end
        end else begin
            m_mode = 0; m_ab = 0;
        end
        e_valid = issue;
        e_h = issue ? m_p % W : p_next % W;
        e_v = issue ? m_p / W : p_next / W;
        m_p = p_next;
        e_busy = (m_mode != 0);
        if (r && !issue) begin
            if (m_cred == CRED) m_err = 1;
            else m_cred++;
        end else if (issue && !r) begin
            m_cred--;
        end
    endtask

    task automatic compare_all();
        bit [3:0] ep;
        ep = pix_due.exists(cyc) ? pix_due[cyc] : 4'b0;
        if (pix_due.exists(cyc)) pix_due.delete(cyc);
        check("valid", valid, e_valid);
        check("hcount", hcount, e_h);
        check("vcount", vcount, e_v);
        check("pixel_valid", pvalid, ep[3]);
        check("sof", sof, ep[2]);
        check("eol", eol, ep[1]);
        check("eof", eof, ep[0]);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("aborted", aborted, e_abo);
        check("credit_err", cerr, m_err);
    endtask

    task automatic seg_clear();
        s_nvalid = 0; s_first_valid = -1; s_first_h = -1; s_first_v = -1;
        s_eof = 0; s_eof_at = -1; s_done_at = -1; s_done_abo = -1;
    endtask

    task automatic step(input bit s, input bit a, input bit r);
        start = s; abort = a; ret = r;
        @(posedge clk);
        model_edge(s, a, r);
        @(negedge clk);
        compare_all();
        if (valid) begin
            if (s_nvalid == 0) begin
                s_first_valid = cyc; s_first_h = hcount; s_first_v = vcount;
            end
            s_nvalid++;
        end
        if (eof) begin s_eof++; s_eof_at = cyc; end
        if (done) begin s_done_at = cyc; s_done_abo = aborted; end
    endtask

    // mode 0: no returns, 1: return each issued credit on the next cycle
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, (mode == 1) ? valid : 1'b0);
        end
    endtask

    initial begin
        model_reset();
        seg_clear();
        @(negedge clk);
        compare_all();
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);

        // full frame with an immediate consumer
        seg_clear();
        base = cyc + 1;
        step(1, 0, 0);
        run(20, 1);
        check("ff_first_cycle", s_first_valid - base, 1);
        check("ff_pixels", s_nvalid, 12);
        check("ff_eof_cycle", s_eof_at - base, 15);
        check("ff_done_cycle", s_done_at - base, 16);
        check("ff_done_aborted", s_done_abo, 0);

        // credit stall: one frame without returns leaves 4 credits
        step(1, 0, 0);
        run(18, 0);
        seg_clear();
        step(1, 0, 0);
        run(20, 0);
        check("stall_pixels", s_nvalid, 4);
        check("stall_hold_h", hcount, 0);
        check("stall_hold_v", vcount, 1);
        check("stall_valid_low", valid, 0);
        seg_clear();
        rc = cyc + 1;
        step(0, 0, 1);
        run(5, 0);
        check("stall_one_issue", s_nvalid, 1);
        check("stall_issue_h", s_first_h, 0);
        check("stall_issue_v", s_first_v, 1);
        check("stall_issue_cycle", s_first_valid - rc, 1);
        seg_clear();
        step(0, 1, 0);
        run(8, 0);
        check("stall_abort_done", s_done_abo, 1);
        for (int i = 0; i < CRED; i++) step(0, 0, 1);

        // issue and return on the same cycles
        seg_clear();
        step(1, 0, 0);
        for (int i = 0; i < NPIX; i++) step(0, 0, 1);
        run(8, 0);
        check("simul_pixels", s_nvalid, 12);
        check("simul_no_err", cerr, 0);
        for (int i = 0; i < NPIX; i++) step(0, 0, 1);

        // abort on the fifth issue cycle
        seg_clear();
        base = cyc + 1;
        step(1, 0, 0);
        run(4, 1);
        step(0, 1, valid);
        run(10, 1);
        check("ab_pixels", s_nvalid, 4);
        check("ab_no_eof", s_eof, 0);
        check("ab_done_cycle", s_done_at - base, 8);
        check("ab_done_aborted", s_done_abo, 1);
        seg_clear();
        step(1, 0, 0);
        run(20, 1);
        check("restart_h", s_first_h, 0);
        check("restart_v", s_first_v, 0);
        check("restart_pixels", s_nvalid, 12);

        // credit overflow is sticky
        step(0, 0, 1);
        check("ovf_err", cerr, 1);
        seg_clear();
        step(1, 0, 0);
        run(20, 1);
        check("ovf_pixels", s_nvalid, 12);
        check("ovf_sticky", cerr, 1);

        // asynchronous reset mid-scan with 11 credits left
        step(1, 0, 0);
        run(5, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_pixel_valid", pvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cerr, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0);
        seg_clear();
        step(1, 0, 0);
        run(20, 0);
        check("rst_reload_pixels", s_nvalid, 12);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step(($urandom % 10) == 0, ($urandom % 25) == 0,
                 (m_cred < CRED) ? (($urandom % 3) != 0) : (($urandom % 80) == 0));
        end
        for (int i = 0; i < 200 && busy; i++) step(0, 0, 0);
        check("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
